// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back, write-allocate data cache placed between the
//   MEM stage and a slow line-wide data memory. Hits are answered in the same
//   cycle. A miss stalls the whole pipeline while the controller writes back
//   a dirty victim (if any) and refills the line over a req/ack handshake.
//
// Ports
//   clk_i        clock, all state updates on the rising edge
//   rst_i        asynchronous, active-low reset
//   cpu_req_i    MEM stage access valid (load or store)
//   cpu_we_i     1 = store word, 0 = load word
//   cpu_addr_i   byte address (bits [1:0] ignored)
//   cpu_data_i   store data
//   cpu_data_o   load data, valid when cpu_req_i & !cpu_stall_o (0 on miss)
//   cpu_stall_o  freeze PC and all pipeline registers
//   mem_req_o    memory transaction request
//   mem_we_o     1 = line write-back, 0 = line read
//   mem_addr_o   line-aligned memory address
//   mem_data_o   victim line for write-back
//   mem_data_i   refill line, sampled in the cycle mem_ack_i = 1
//   mem_ack_i    one-cycle completion pulse for the current request
// ---------------------------------------------------------------------------
module dcache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int NUM_LINES  = 32,
    localparam int LINE_W    = 8 * LINE_BYTES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        RESUME
    } state_t;

    state_t state_reg, state_next;

    logic [NUM_LINES-1:0] valid_reg;
    logic [NUM_LINES-1:0] dirty_reg;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic [OFF_W-3:0] word_sel;
    logic [OFF_W+2:0] bit_base;
    logic [1:0]       addr_unused;
    logic             hit;
    logic             write_hit;
    logic             fill;
    logic             wb_done;

    assign idx         = cpu_addr_i[OFF_W+IDX_W-1:OFF_W];
    assign req_tag     = cpu_addr_i[ADDR_W-1:OFF_W+IDX_W];
    assign word_sel    = cpu_addr_i[OFF_W-1:2];
    assign bit_base    = {word_sel, 5'd0};
    // Byte-within-word bits carry no meaning for word accesses.
    assign addr_unused = cpu_addr_i[1:0];

    assign hit        = cpu_req_i & valid_reg[idx] & (tag_mem[idx] == req_tag);
    assign cpu_data_o = hit ? data_mem[idx][bit_base +: 32] : 32'd0;

    // Stores only commit from IDLE; a store that missed re-presents itself in
    // IDLE after RESUME and merges into the freshly filled line then.
    assign write_hit = (state_reg == IDLE) & hit & cpu_we_i;
    assign fill      = (state_reg == ALLOCATE) & mem_ack_i;
    assign wb_done   = (state_reg == WRITEBACK) & mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else begin
            if (fill) begin
                valid_reg[idx] <= 1'b1;
            end
            if (fill || wb_done) begin
                dirty_reg[idx] <= 1'b0;
            end else if (write_hit) begin
                dirty_reg[idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid_reg guards every use.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_mem[idx] <= mem_data_i;
            tag_mem[idx]  <= req_tag;
        end else if (write_hit) begin
            data_mem[idx][bit_base +: 32] <= cpu_data_i;
        end
    end

    // Memory-side outputs depend only on state and stored contents, so they
    // are stable for the whole life of a request (cpu_addr_i is held by the
    // stalled pipeline).
    always_comb begin
        state_next  = state_reg;
        cpu_stall_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (state_reg)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    // Reset held low must never present a stall to the pipeline.
                    cpu_stall_o = rst_i;
                    state_next  = (valid_reg[idx] && dirty_reg[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_mem[idx], idx, {OFF_W{1'b0}}};
                mem_data_o  = data_mem[idx];
                if (mem_ack_i) begin
                    state_next = ALLOCATE;
                end
            end
            ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {req_tag, idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    state_next = RESUME;
                end
            end
            RESUME: begin
                cpu_stall_o = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
